// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Instruction-memory fetch bus between the PC sequencer and
//                the instruction-memory wrapper. The request is held until
//                granted. Read data returns on a later rvalid.
//  Signals     : imem_req    - fetch request, held until imem_gnt
//                imem_addr   - fetch address (XLEN bits)
//                imem_gnt    - request accepted this cycle
//                imem_rvalid - imem_rdata valid this cycle
//                imem_rdata  - fetched 32-bit instruction
//  Modports    : master (sequencer side), slave (memory side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter and fetch sequencer. Fetches over the imem
//                bus, holds each instruction until execute retires it, and
//                resolves branches, jal and jalr internally. A retire to a
//                misaligned target redirects to TRAP_VECTOR and pulses trap.
//  Ports       : clk, rst (async, active high)
//                imem       - fetch bus (pc_sequencer_if.master)
//                inst, inst_valid, pc, link_addr - to decode/execute
//                branch, funct3, jump, jalr, rs1_data, rs2_data, imm32
//                           - control-flow inputs for the current inst
//                exec_done, stall - retire control
//                trap, trap_epc   - misaligned-target trap report
//  Options     : `define PC_PERF_CNT_EN adds retired_cnt and taken_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pc_sequencer_if.master       imem,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      link_addr,
    input  wire logic            branch,
    input  wire logic [2:0]      funct3,
    input  wire logic            jump,
    input  wire logic            jalr,
    input  wire logic [XLEN-1:0] rs1_data,
    input  wire logic [XLEN-1:0] rs2_data,
    input  wire logic [XLEN-1:0] imm32,
    input  wire logic            exec_done,
    input  wire logic            stall,
    output logic                 trap,
    output logic [XLEN-1:0]      trap_epc
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]          retired_cnt,
    output logic [31:0]          taken_cnt
`endif
);

    localparam logic [XLEN-1:0] c_FOUR      = XLEN'(4);
    localparam logic [XLEN-1:0] c_JALR_MASK = ~XLEN'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [XLEN-1:0] r_pc_q, w_pc_d;
    logic [31:0]     r_inst_q, w_inst_d;
    logic            r_trap_q, w_trap_d;
    logic [XLEN-1:0] r_trap_epc_q, w_trap_epc_d;

    // ------------------------------------------------------------------
    // Control-flow resolution
    // ------------------------------------------------------------------
    logic            w_eq, w_lt_s, w_lt_u, w_taken;
    logic [XLEN-1:0] w_link, w_pc_rel, w_jalr_tgt, w_next_pc;
    logic            w_misaligned, w_retire;

    assign w_eq   = (rs1_data == rs2_data);
    assign w_lt_s = ($signed(rs1_data) < $signed(rs2_data));
    assign w_lt_u = (rs1_data < rs2_data);

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = ~w_eq;
            3'b100:  w_taken = w_lt_s;
            3'b101:  w_taken = ~w_lt_s;
            3'b110:  w_taken = w_lt_u;
            3'b111:  w_taken = ~w_lt_u;
            default: w_taken = 1'b0;
        endcase
    end

    // All sums wrap modulo 2^XLEN by construction.
    assign w_link     = r_pc_q + c_FOUR;
    assign w_pc_rel   = r_pc_q + imm32;
    assign w_jalr_tgt = (rs1_data + imm32) & c_JALR_MASK;

    always_comb begin
        w_next_pc = w_link;
        if (jalr) begin
            w_next_pc = w_jalr_tgt;
        end else if (jump) begin
            w_next_pc = w_pc_rel;
        end else if (branch && w_taken) begin
            w_next_pc = w_pc_rel;
        end
    end

    // pc+4 is always aligned when pc is, so only redirects can trap.
    assign w_misaligned = |w_next_pc[1:0];
    assign w_retire     = (r_state_q == S_ISSUE) && exec_done && !stall;

    // ------------------------------------------------------------------
    // Fetch / issue FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_inst_d     = r_inst_q;
        w_trap_d     = 1'b0;
        w_trap_epc_d = r_trap_epc_q;
        case (r_state_q)
            S_IDLE: begin
                w_state_d = S_REQ;
            end
            S_REQ: begin
                // rvalid here belongs to no outstanding request; drop it.
                if (imem.imem_gnt) begin
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    w_inst_d  = imem.imem_rdata;
                    w_state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_retire) begin
                    w_state_d = S_REQ;
                    if (w_misaligned) begin
                        w_pc_d       = TRAP_VECTOR;
                        w_trap_d     = 1'b1;
                        w_trap_epc_d = r_pc_q;
                    end else begin
                        w_pc_d = w_next_pc;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_pc_q       <= RESET_VECTOR;
            r_inst_q     <= '0;
            r_trap_q     <= 1'b0;
            r_trap_epc_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_pc_q       <= w_pc_d;
            r_inst_q     <= w_inst_d;
            r_trap_q     <= w_trap_d;
            r_trap_epc_q <= w_trap_epc_d;
        end
    end

    assign imem.imem_req  = (r_state_q == S_REQ);
    assign imem.imem_addr = r_pc_q;
    assign inst           = r_inst_q;
    assign inst_valid     = (r_state_q == S_ISSUE);
    assign pc             = r_pc_q;
    assign link_addr      = w_link;
    assign trap           = r_trap_q;
    assign trap_epc       = r_trap_epc_q;

`ifdef PC_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters; a trapping retire counts as retired only.
    // ------------------------------------------------------------------
    logic [31:0] r_retired_cnt_q, w_retired_cnt_d;
    logic [31:0] r_taken_cnt_q, w_taken_cnt_d;

    always_comb begin
        w_retired_cnt_d = r_retired_cnt_q;
        w_taken_cnt_d   = r_taken_cnt_q;
        if (w_retire) begin
            w_retired_cnt_d = r_retired_cnt_q + 32'd1;
            if (!w_misaligned && (w_next_pc != w_link)) begin
                w_taken_cnt_d = r_taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_cnt_q <= '0;
            r_taken_cnt_q   <= '0;
        end else begin
            r_retired_cnt_q <= w_retired_cnt_d;
            r_taken_cnt_q   <= w_taken_cnt_d;
        end
    end

    assign retired_cnt = r_retired_cnt_q;
    assign taken_cnt   = r_taken_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Directed scenarios
//                followed by randomized fetch/retire traffic, checked
//                against a behavioural model of the PC rules.
//  Options     : `define PC_PERF_CNT_EN also checks the perf counters
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int          XLEN           = 32;
    localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] c_TRAP_VECTOR  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst, pc, link_addr, trap_epc;
    logic        inst_valid, trap;
    logic        branch = 1'b0, jump = 1'b0, jalr = 1'b0;
    logic        exec_done = 1'b0, stall = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = '0, rs2_data = '0, imm32 = '0;
`ifdef PC_PERF_CNT_EN
    logic [31:0] retired_cnt, taken_cnt;
`endif

    pc_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (c_RESET_VECTOR),
        .TRAP_VECTOR  (c_TRAP_VECTOR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .link_addr  (link_addr),
        .branch     (branch),
        .funct3     (funct3),
        .jump       (jump),
        .jalr       (jalr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm32      (imm32),
        .exec_done  (exec_done),
        .stall      (stall),
        .trap       (trap),
        .trap_epc   (trap_epc)
`ifdef PC_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_inst, m_epc, m_retired, m_taken;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule for the current instruction.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic br,
                                             input logic [2:0] f3, input logic j, input logic jr,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] imm);
        logic tk;
        int signed sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = (sa < sb);
            3'd5:    tk = (sa >= sb);
            3'd6:    tk = (a < b);
            3'd7:    tk = (a >= b);
            default: tk = 1'b0;
        endcase
        if (jr) return (a + imm) & 32'hFFFF_FFFE;
        if (j) return cur + imm;
        if (br && tk) return cur + imm;
        return cur + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc      = c_RESET_VECTOR;
        m_inst    = '0;
        m_epc     = '0;
        m_retired = '0;
        m_taken   = '0;
    endtask

    task automatic check_reset_state();
        check("rst_pc", pc, c_RESET_VECTOR);
        check("rst_inst", inst, 32'h0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check1("rst_req", bus.imem_req, 1'b0);
        check1("rst_trap", trap, 1'b0);
        check("rst_epc", trap_epc, 32'h0);
`ifdef PC_PERF_CNT_EN
        check("rst_retired", retired_cnt, 32'h0);
        check("rst_taken", taken_cnt, 32'h0);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        exec_done = 1'b0;
        stall = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Serve one fetch; optionally present junk rvalid while in REQ.
    task automatic fetch(input logic [31:0] data, input int gnt_dly, input int rv_dly, input bit dual);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check1("req_seen", bus.imem_req, 1'b1);
        check("imem_addr", bus.imem_addr, m_pc);
        for (int i = 0; i < gnt_dly; i++) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = ~data;
            exec_done       = 1'($urandom);
            @(negedge clk);
            check1("req_held", bus.imem_req, 1'b1);
        end
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = dual;
        bus.imem_rdata  = ~data;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        check1("req_drop", bus.imem_req, 1'b0);
        check1("wait_not_valid", inst_valid, 1'b0);
        check("wait_inst_kept", inst, m_inst);
        for (int i = 0; i < rv_dly; i++) begin
            exec_done = 1'($urandom);
            @(negedge clk);
        end
        exec_done       = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        m_inst = data;
        check1("inst_valid", inst_valid, 1'b1);
        check("inst", inst, m_inst);
        check("issue_pc", pc, m_pc);
    endtask

    task automatic retire(input logic br, input logic [2:0] f3, input logic j, input logic jr,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input int stall_cycles);
        logic [31:0] tgt;
        logic        exp_trap;
        check("link_addr", link_addr, m_pc + 32'd4);
        branch = br; funct3 = f3; jump = j; jalr = jr;
        rs1_data = a; rs2_data = b; imm32 = imm;
        exec_done = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
            @(negedge clk);
            check1("stall_valid", inst_valid, 1'b1);
            check("stall_pc", pc, m_pc);
            check("stall_inst", inst, m_inst);
        end
        stall = 1'b0;
        @(negedge clk);
        exec_done = 1'b0;
        tgt = ref_next(m_pc, br, f3, j, jr, a, b, imm);
        exp_trap = (tgt[1:0] != 2'b00);
        m_retired = m_retired + 32'd1;
        if (exp_trap) begin
            m_epc = m_pc;
            m_pc  = c_TRAP_VECTOR;
        end else begin
            if (tgt != m_pc + 32'd4) m_taken = m_taken + 32'd1;
            m_pc = tgt;
        end
        branch = 1'b0; jump = 1'b0; jalr = 1'b0;
        check1("trap", trap, exp_trap);
        check("next_pc", pc, m_pc);
        check("trap_epc", trap_epc, m_epc);
        check1("valid_fall", inst_valid, 1'b0);
`ifdef PC_PERF_CNT_EN
        check("retired_cnt", retired_cnt, m_retired);
        check("taken_cnt", taken_cnt, m_taken);
`endif
        @(negedge clk);
        check1("trap_pulse_end", trap, 1'b0);
    endtask

    task automatic goto_pc(input logic [31:0] target);
        retire(1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, target - m_pc, 0);
        fetch(32'h0000_006F, 1, 0, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        model_reset();

        // Reset then a first fetch at the reset vector
        apply_reset();
        fetch(32'h0000_0013, 1, 0, 1'b0);
        retire(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        check("first_seq_pc", pc, 32'h4);
        fetch(32'h0000_0013, 0, 1, 1'b0);

        // bltu vs blt from 0x40
        goto_pc(32'h40);
        retire(1'b1, 3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h10, 0);
        check("bltu_not_taken", pc, 32'h44);
        fetch(32'h0000_0063, 0, 0, 1'b1);
        goto_pc(32'h40);
        retire(1'b1, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h10, 0);
        check("blt_taken", pc, 32'h50);
        fetch(32'h0000_0067, 2, 1, 1'b0);

        // jalr clears bit 0
        retire(1'b0, 3'd0, 1'b0, 1'b1, 32'h201, 32'h0, 32'h4, 0);
        check("jalr_target", pc, 32'h204);
        fetch(32'h0000_0013, 0, 0, 1'b0);

        // jal to misaligned target traps
        goto_pc(32'h40);
        retire(1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h6, 0);
        check("trap_vector", pc, 32'h100);
        check("trap_epc_40", trap_epc, 32'h40);
        fetch(32'h0000_0013, 1, 1, 1'b1);

        // Stall holds retire for 5 cycles
        retire(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5);
        check("after_stall_pc", pc, 32'h104);

        // Reset mid-fetch: rvalid after release must not load inst
        while (bus.imem_req !== 1'b1) @(negedge clk);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        bus.imem_rvalid = 1'b0;
        check("midreset_inst", inst, 32'h0);
        check1("midreset_valid", inst_valid, 1'b0);
        fetch(32'h0000_0013, 0, 0, 1'b0);

        // Wrap-around at the top of the address space
        goto_pc(32'hFFFF_FFFC);
        retire(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        check("wrap_pc", pc, 32'h0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            logic [31:0] a, b, imm;
            int kind;
            fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
            a    = pick_operand();
            b    = ($urandom_range(0, 3) == 0) ? a : pick_operand();
            imm  = 32'($urandom_range(0, 63) * 4) - 32'd128;
            if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
            kind = $urandom_range(0, 3);
            retire(kind == 1, 3'($urandom), kind == 2, kind == 3, a, b, imm, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
